// File: rtl/crc24_attach_if.sv
// Stream interface of the CRC24A attach stage: payload bits in, framed
// K-bit stream plus interleaver framing controls out.
interface crc24_attach_if;
  logic data_in;
  logic data_valid;
  logic frame_start;
  logic blocksize_sel;
  logic in_ready;
  logic data_out;
  logic CRC_start;
  logic CRC_blocksize;
  logic CRC_end;
  logic frame_error;

  modport master (
    output data_in, data_valid, frame_start, blocksize_sel,
    input  in_ready, data_out, CRC_start, CRC_blocksize, CRC_end, frame_error
  );

  modport slave (
    input  data_in, data_valid, frame_start, blocksize_sel,
    output in_ready, data_out, CRC_start, CRC_blocksize, CRC_end, frame_error
  );
endinterface

// File: rtl/crc24_attach.sv
// Serial gCRC24A attachment: forwards a K-24 bit payload and appends the
// 24-bit parity MSB-first, with framing pulses for the turbo interleaver.
module crc24_attach #(
  parameter int unsigned           K_SMALL = 1056,
  parameter int unsigned           K_LARGE = 6144,
  parameter int unsigned           CRC_LEN = 24,
  parameter logic [CRC_LEN-1:0]    POLY    = 24'h864CFB,
  parameter int unsigned           CNT_W   = 13
) (
  input logic           clk,
  input logic           reset,
  crc24_attach_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  localparam logic [CNT_W-1:0] LEN_S    = CNT_W'(K_SMALL - CRC_LEN);
  localparam logic [CNT_W-1:0] LEN_L    = CNT_W'(K_LARGE - CRC_LEN);
  localparam logic [CNT_W-1:0] LAST_PAR = CNT_W'(CRC_LEN - 1);

  state_t             state_q, state_d;
  logic [CRC_LEN-1:0] crc_q, crc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc, len_w;
  logic               size_q, size_d;
  logic               dout_q, dout_d;
  logic               start_q, start_d;
  logic               end_q, end_d;
  logic               err_q, err_d;
  logic               rdy_q, rdy_d;

  function automatic logic [CRC_LEN-1:0] crc_step(input logic [CRC_LEN-1:0] c,
                                                  input logic b);
    crc_step = {c[CRC_LEN-2:0], 1'b0} ^ ((b ^ c[CRC_LEN-1]) ? POLY : '0);
  endfunction

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    dout_d  = 1'b0;
    start_d = 1'b0;
    end_d   = 1'b0;
    err_d   = 1'b0;
    rdy_d   = rdy_q;
    cnt_inc = cnt_q + CNT_W'(1);
    len_w   = size_q ? LEN_L : LEN_S;

    case (state_q)
      IDLE: begin
        if (bus.data_valid && bus.frame_start) begin
          size_d  = bus.blocksize_sel;
          crc_d   = crc_step('0, bus.data_in);
          cnt_d   = CNT_W'(1);
          dout_d  = bus.data_in;
          start_d = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus.data_valid) begin
          crc_d  = crc_step(crc_q, bus.data_in);
          dout_d = bus.data_in;
          cnt_d  = cnt_inc;
          // in_ready drops together with the last payload bit so parity is gapless
          if (cnt_inc == len_w) begin
            state_d = PARITY;
            cnt_d   = '0;
            rdy_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end
      end
      PARITY: begin
        dout_d = crc_q[CRC_LEN-1];
        crc_d  = {crc_q[CRC_LEN-2:0], 1'b0};
        cnt_d  = cnt_inc;
        if (cnt_q == LAST_PAR) begin
          end_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          rdy_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      crc_q   <= '0;
      cnt_q   <= '0;
      size_q  <= 1'b0;
      dout_q  <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      dout_q  <= dout_d;
      start_q <= start_d;
      end_q   <= end_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.in_ready      = rdy_q;
  assign bus.data_out      = dout_q;
  assign bus.CRC_start     = start_q;
  assign bus.CRC_blocksize = size_q;
  assign bus.CRC_end       = end_q;
  assign bus.frame_error   = err_q;

endmodule

// File: tb/tb_crc24_attach.sv
// Scoreboard bench for crc24_attach: stimulus queues expected frames/bits,
// a negedge monitor pops and compares whenever the DUT emits a frame.
module tb_crc24_attach;
  localparam logic [23:0] POLY = 24'h864CFB;

  typedef struct {
    int len;    // output bits expected (full frame) or payload bits before abort
    bit bsize;
    int kind;   // 0 complete, 1 data_valid drop, 2 reset
    int gap;    // cycles from previous CRC_end to this CRC_start, 0 = unchecked
  } frame_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  crc24_attach_if bus();

  crc24_attach #(
    .K_SMALL(1056),
    .K_LARGE(6144),
    .CRC_LEN(24),
    .POLY(24'h864CFB),
    .CNT_W(13)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  frame_t fq[$];
  logic   bq[$];
  logic   pay [0:6143];

  int n_chk = 0;
  int n_fail = 0;
  int idle_err = 0;
  bit in_frame = 1'b0;

  frame_t      cur;
  int          cnt, bit_err, bs_err, ctl_err, first_bad, cyc, last_end;
  logic [23:0] lfsr;
  logic        eb, fb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] ref_crc(input int n);
    logic [23:0] c;
    logic        f;
    c = '0;
    for (int i = 0; i < n; i++) begin
      f = pay[i] ^ c[23];
      c = {c[22:0], 1'b0} ^ (f ? POLY : 24'h0);
    end
    return c;
  endfunction

  task automatic check_rst_outputs();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_data_out", bus.data_out, 0);
    check("rst_crc_start", bus.CRC_start, 0);
    check("rst_crc_blocksize", bus.CRC_blocksize, 0);
    check("rst_crc_end", bus.CRC_end, 0);
    check("rst_frame_error", bus.frame_error, 0);
  endtask

  task automatic send_frame(input int n, input bit bs, input int kind, input int stop,
                            input logic [23:0] hand_par, input bit use_hand, input int gap);
    frame_t      f;
    int          plen, t;
    logic [23:0] par;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("in_ready_before_frame", bus.in_ready, 1);
    plen    = (kind == 0) ? n : stop;
    f.len   = (kind == 0) ? n + 24 : stop;
    f.bsize = bs;
    f.kind  = kind;
    f.gap   = gap;
    par = use_hand ? hand_par : ref_crc(n);
    fq.push_back(f);
    for (int i = 0; i < plen; i++) bq.push_back(pay[i]);
    if (kind == 0) for (int j = 23; j >= 0; j--) bq.push_back(par[j]);
    for (int i = 0; i < plen; i++) begin
      bus.data_valid    = 1'b1;
      bus.frame_start   = (i == 0);
      bus.blocksize_sel = (i == 0) ? bs : ~bs;
      bus.data_in       = pay[i];
      @(posedge clk); #1;
    end
    bus.data_valid  = 1'b0;
    bus.frame_start = 1'b0;
    bus.data_in     = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin
    cyc = 0;
    last_end = -1000;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        if (in_frame) begin
          check("reset_abort_kind", cur.kind, 2);
          check("reset_abort_pos", cnt, cur.len);
          check("reset_abort_data_errs", bit_err, 0);
          in_frame = 1'b0;
        end
      end else begin
        if (bus.CRC_start) begin
          check("crc_start_outside_frame", {31'b0, in_frame}, 0);
          check("crc_start_expected", {31'b0, fq.size() != 0}, 1);
          if (fq.size() != 0) begin
            cur = fq.pop_front();
            in_frame = 1'b1;
            cnt = 0; bit_err = 0; bs_err = 0; ctl_err = 0; first_bad = -1;
            lfsr = '0;
            if (cur.gap > 0) check("frame_gap", cyc - last_end, cur.gap);
          end
        end
        if (in_frame && cur.kind != 0 && cnt == cur.len) begin
          check("abort_frame_error", bus.frame_error, {31'b0, cur.kind == 1});
          check("abort_crc_end", bus.CRC_end, 0);
          check("abort_data_errs", bit_err, 0);
          check("abort_bsize_errs", bs_err, 0);
          in_frame = 1'b0;
        end else if (in_frame) begin
          if (bus.frame_error) ctl_err++;
          if (bq.size() != 0) eb = bq.pop_front();
          else eb = 1'bx;
          if (bus.data_out !== eb) begin
            if (bit_err == 0) first_bad = cnt;
            bit_err++;
          end
          if (bus.CRC_blocksize !== cur.bsize) bs_err++;
          fb   = bus.data_out ^ lfsr[23];
          lfsr = {lfsr[22:0], 1'b0} ^ (fb ? POLY : 24'h0);
          if ((cur.kind == 0 && cnt == cur.len - 1) || bus.CRC_end) begin
            check("crc_end_flag", bus.CRC_end, 1);
            check("crc_end_pos", cnt, cur.len - 1);
            check("crc_end_kind", cur.kind, 0);
            check("frame_data_errs", bit_err, 0);
            if (bit_err != 0) check("frame_first_bad_bit", first_bad, cur.len);
            check("frame_bsize_errs", bs_err, 0);
            check("frame_ctl_errs", ctl_err, 0);
            check("frame_lfsr_remainder", lfsr, 0);
            in_frame = 1'b0;
            last_end = cyc;
          end
          cnt++;
        end else begin
          if (bus.data_out || bus.CRC_end || bus.frame_error) idle_err++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t;
    bus.data_in = 1'b0;
    bus.data_valid = 1'b0;
    bus.frame_start = 1'b0;
    bus.blocksize_sel = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_rst_outputs();
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: small all-zero frame, zero parity
    for (int i = 0; i < 1032; i++) pay[i] = 1'b0;
    send_frame(1032, 1'b0, 0, 0, 24'h000000, 1'b1, 0);

    // 2: single trailing one leaves the generator itself as parity
    pay[1031] = 1'b1;
    send_frame(1032, 1'b0, 0, 0, 24'h864CFB, 1'b1, 0);

    // 3: large random frame, blocksize_sel toggled mid-frame
    for (int i = 0; i < 6120; i++) pay[i] = 1'($urandom_range(1, 0));
    send_frame(6120, 1'b1, 0, 0, 24'h0, 1'b0, 0);

    // 4: data_valid drop at payload bit 500, then a clean frame
    for (int i = 0; i < 1032; i++) pay[i] = ((i % 3) == 0);
    send_frame(1032, 1'b0, 1, 500, 24'h0, 1'b0, 0);
    @(posedge clk); #1;
    check("in_ready_after_abort", bus.in_ready, 1);
    send_frame(1032, 1'b0, 0, 0, 24'h0, 1'b0, 0);

    // 5: junk during parity is ignored; next frame one cycle after CRC_end
    for (int i = 0; i < 1032; i++) pay[i] = (((i * 7) % 5) == 1);
    send_frame(1032, 1'b0, 0, 0, 24'h0, 1'b0, 0);
    bus.data_valid = 1'b1;
    bus.frame_start = 1'b1;
    bus.data_in = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 40) begin
      k++;
      @(posedge clk); #1;
    end
    check("parity_in_ready_low_cycles", k, 24);
    send_frame(1032, 1'b0, 0, 0, 24'h0, 1'b0, 1);

    // 6: reset at payload bit 300 of a large frame
    for (int i = 0; i < 6120; i++) pay[i] = 1'($urandom_range(1, 0));
    send_frame(6120, 1'b1, 2, 300, 24'h0, 1'b0, 0);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check_rst_outputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send_frame(6120, 1'b1, 0, 0, 24'h0, 1'b0, 0);

    t = 0;
    while ((fq.size() != 0 || in_frame) && t < 500) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk); #1;
    check("drain_frames", fq.size(), 0);
    check("drain_in_frame", {31'b0, in_frame}, 0);
    check("drain_bits", bq.size(), 0);
    check("idle_output_errs", idle_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
